// File: rtl/tagged_range_filter_pkg.sv
// Shared types and constants for the tagged range filter and its skid buffer.
// Optional statistics are enabled with the TAGGED_RANGE_FILTER_STATS_EN macro.
package tagged_range_filter_pkg;

  localparam int unsigned SERIAL_WIDTH_DEFAULT = 16;
  localparam int unsigned STATS_WIDTH = 32;

  typedef logic [SERIAL_WIDTH_DEFAULT-1:0] serial_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Saturating accumulate so a long stream pins at all-ones instead of wrapping.
  function automatic logic [STATS_WIDTH-1:0] sat_add(input logic [STATS_WIDTH-1:0] a,
                                                     input logic [STATS_WIDTH-1:0] b);
    logic [STATS_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STATS_WIDTH] ? '1 : sum[STATS_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/tagged_range_filter_if.sv
// Tagged element stream: a beat of NUM_ELEMENTS elements, each with a serial tag and keep bit.
interface ntagged_i #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 4,
  parameter int  SERIAL_WIDTH = 16
);

  logic                                       valid;
  logic                                       ready;
  data_t [NUM_ELEMENTS-1:0]                   data;
  logic  [NUM_ELEMENTS-1:0][SERIAL_WIDTH-1:0] tag;
  logic  [NUM_ELEMENTS-1:0]                   keep;
  logic                                       last;

  modport m (output valid, data, tag, keep, last, input ready);
  modport s (input valid, data, tag, keep, last, output ready);

endinterface

// File: rtl/tagged_range_filter_skid_buffer.sv
// Two-entry registered slice over an ntagged_i stream; ready is a flop, so
// there is no combinational path from downstream ready to upstream ready.
module tagged_skid_buffer #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 4,
  parameter int  SERIAL_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  ntagged_i.s in,
  ntagged_i.m out
);

  typedef struct packed {
    data_t [NUM_ELEMENTS-1:0]                   data;
    logic  [NUM_ELEMENTS-1:0][SERIAL_WIDTH-1:0] tag;
    logic  [NUM_ELEMENTS-1:0]                   keep;
    logic                                       last;
  } beat_t;

  beat_t       entry_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        ready_q;
  logic        push;
  logic        pop;
  logic [1:0]  count_next;

  always_comb begin
    push       = in.valid && ready_q;
    pop        = (count_q != 2'd0) && out.ready;
    count_next = count_q + 2'(push) - 2'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  // NOTE: payload storage has no reset; count_q alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr_q] <= '{data: in.data, tag: in.tag, keep: in.keep, last: in.last};
  end

  assign in.ready  = ready_q;
  assign out.valid = (count_q != 2'd0);
  assign out.data  = entry_q[rd_ptr_q].data;
  assign out.tag   = entry_q[rd_ptr_q].tag;
  assign out.keep  = entry_q[rd_ptr_q].keep;
  assign out.last  = entry_q[rd_ptr_q].last;

endmodule

// File: rtl/tagged_range_filter.sv
// Keeps elements whose tag lies in [lo, hi), drops empty non-last beats, and
// optionally counts kept elements per stream (TAGGED_RANGE_FILTER_STATS_EN).
module tagged_range_filter
  import tagged_range_filter_pkg::*;
#(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 4,
  parameter int  SERIAL_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SERIAL_WIDTH-1:0] cfg_lo,
  input  logic [SERIAL_WIDTH-1:0] cfg_hi,
  ntagged_i.s                     in,
  ntagged_i.m                     out
`ifdef TAGGED_RANGE_FILTER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]  stat_kept,
  output logic                    stat_valid
`endif
);

  state_t                    state_q;
  logic [SERIAL_WIDTH-1:0]   lo_q;
  logic [SERIAL_WIDTH-1:0]   hi_q;
  logic [SERIAL_WIDTH-1:0]   lo;
  logic [SERIAL_WIDTH-1:0]   hi;
  logic [NUM_ELEMENTS-1:0]   kept;
  logic                      forward;
  logic                      in_fire;

  ntagged_i #(.data_t(data_t), .NUM_ELEMENTS(NUM_ELEMENTS), .SERIAL_WIDTH(SERIAL_WIDTH)) filt ();

  // The first beat of a stream sees the live window; later beats see the latched copy.
  always_comb begin
    lo   = (state_q == IDLE) ? cfg_lo : lo_q;
    hi   = (state_q == IDLE) ? cfg_hi : hi_q;
    kept = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      kept[i] = in.keep[i] && (in.tag[i] >= lo) && (in.tag[i] < hi);
    end
    forward = (|kept) || in.last;
    in_fire = in.valid && filt.ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
    end else if (in_fire) begin
      case (state_q)
        IDLE: begin
          lo_q    <= cfg_lo;
          hi_q    <= cfg_hi;
          state_q <= in.last ? IDLE : STREAM;
        end
        STREAM: if (in.last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Dropped beats still complete the input handshake but never enter the skid.
  assign in.ready   = filt.ready;
  assign filt.valid = in.valid && forward;
  assign filt.data  = in.data;
  assign filt.tag   = in.tag;
  assign filt.keep  = kept;
  assign filt.last  = in.last;

  tagged_skid_buffer #(
    .data_t      (data_t),
    .NUM_ELEMENTS(NUM_ELEMENTS),
    .SERIAL_WIDTH(SERIAL_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (filt),
    .out  (out)
  );

`ifdef TAGGED_RANGE_FILTER_STATS_EN
  logic [STATS_WIDTH-1:0] count_q;
  logic [STATS_WIDTH-1:0] count_next;
  logic                   out_fire;

  always_comb begin
    out_fire   = out.valid && out.ready;
    count_next = sat_add(count_q, STATS_WIDTH'($countones(out.keep)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      stat_kept  <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (out_fire) begin
        if (out.last) begin
          stat_kept  <= count_next;
          stat_valid <= 1'b1;
          count_q    <= '0;
        end else begin
          count_q <= count_next;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tagged_range_filter.sv
// Self-checking bench for tagged_range_filter: a queue-based reference model
// predicts every output beat; directed scenarios pin the model with literal values.
module tb_tagged_range_filter;

  typedef struct packed {
    logic [3:0][7:0]  data;
    logic [3:0][15:0] tag;
    logic [3:0]       keep;
    logic             last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_lo = '0;
  logic [15:0] cfg_hi = '0;

  int checks = 0;
  int passes = 0;

  beat_t exp_q[$];
  beat_t out_log[$];
  beat_t hold;
  logic  hold_pending = 1'b0;
  logic  watch_ready = 1'b0;
  logic  in_stream = 1'b0;
  logic [15:0] win_lo, win_hi;

`ifdef TAGGED_RANGE_FILTER_STATS_EN
  logic [31:0] stat_kept;
  logic        stat_valid;
  int          stat_pulses = 0;
  logic [31:0] stat_last = '0;
`endif

  ntagged_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(4), .SERIAL_WIDTH(16)) in_if ();
  ntagged_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(4), .SERIAL_WIDTH(16)) out_if ();

  tagged_range_filter #(
    .data_t      (logic [7:0]),
    .NUM_ELEMENTS(4),
    .SERIAL_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi),
    .in    (in_if),
    .out   (out_if)
`ifdef TAGGED_RANGE_FILTER_STATS_EN
    ,
    .stat_kept (stat_kept),
    .stat_valid(stat_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [127:0] pack(input beat_t b);
    return 128'({b.data, b.tag, b.keep, b.last});
  endfunction

  function automatic beat_t mk_beat(input int base, input logic [3:0] keep, input logic last);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.tag[i]  = 16'(base + i);
      b.data[i] = 8'(base * 5 + i + 1);
    end
    b.keep = keep;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t out_snapshot();
    beat_t b;
    b.data = out_if.data;
    b.tag  = out_if.tag;
    b.keep = out_if.keep;
    b.last = out_if.last;
    return b;
  endfunction

  // Reference: window captured at stream start; element kept iff inside it.
  function automatic void model_accept(input beat_t b);
    beat_t e;
    int t;
    if (!in_stream) begin
      win_lo = cfg_lo;
      win_hi = cfg_hi;
    end
    e = b;
    for (int i = 0; i < 4; i++) begin
      t = int'(b.tag[i]);
      e.keep[i] = b.keep[i] && (t >= int'(win_lo)) && (t < int'(win_hi));
    end
    if (e.keep != 4'b0000 || b.last) exp_q.push_back(e);
    in_stream = !b.last;
  endfunction

  // Compare process: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t cur, e;
    if (rst_n) begin
      cur = out_snapshot();
      if (hold_pending && out_if.valid) check("hold_stable", pack(cur), pack(hold));
      if (watch_ready) check("ready_hold", 128'(in_if.ready), 128'(1));
      if (out_if.valid) begin
        if (out_if.ready) begin
          check("beat_pending", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_beat", pack(cur), pack(e));
          end
          out_log.push_back(cur);
          hold_pending = 1'b0;
        end else begin
          hold = cur;
          hold_pending = 1'b1;
        end
      end
`ifdef TAGGED_RANGE_FILTER_STATS_EN
      if (stat_valid) begin
        stat_pulses++;
        stat_last = stat_kept;
      end
`endif
    end
  end

  task automatic drive(input beat_t b);
    in_if.valid = 1'b1;
    in_if.data  = b.data;
    in_if.tag   = b.tag;
    in_if.keep  = b.keep;
    in_if.last  = b.last;
  endtask

  task automatic send(input beat_t b);
    int waited = 0;
    drive(b);
    @(negedge clk);
    while (!in_if.ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("in_accept", 128'(in_if.ready), 128'(1));
    if (in_if.ready) model_accept(b);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || out_if.valid) && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    in_stream = 1'b0;
    hold_pending = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_if.valid), 128'(0));
    check("rst_in_ready", 128'(in_if.ready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 128'(in_if.ready), 128'(1));
    check("valid_after_rst", 128'(out_if.valid), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int lo, input int hi);
    cfg_lo = 16'(lo);
    cfg_hi = 16'(hi);
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.data = '0;
    in_if.tag = '0;
    in_if.keep = '0;
    in_if.last = 1'b0;
    out_if.ready = 1'b1;
    do_reset();

    // Window [2,7): three beats, all forwarded.
    set_cfg(2, 7);
    out_log.delete();
`ifdef TAGGED_RANGE_FILTER_STATS_EN
    stat_pulses = 0;
`endif
    send(mk_beat(0, 4'b1111, 1'b0));
    send(mk_beat(4, 4'b1111, 1'b0));
    send(mk_beat(8, 4'b1111, 1'b1));
    drain();
    check("s1_count", 128'(out_log.size()), 128'(3));
    if (out_log.size() == 3) begin
      check("s1_keep0", 128'(out_log[0].keep), 128'(4'b1100));
      check("s1_keep1", 128'(out_log[1].keep), 128'(4'b0111));
      check("s1_keep2", 128'(out_log[2].keep), 128'(4'b0000));
      check("s1_last2", 128'(out_log[2].last), 128'(1));
    end
`ifdef TAGGED_RANGE_FILTER_STATS_EN
    check("s1_pulses", 128'(stat_pulses), 128'(1));
    check("s1_stat_kept", 128'(stat_last), 128'(5));
`endif

    // Window [8,12): first two beats dropped, ready stays high.
    set_cfg(8, 12);
    out_log.delete();
    watch_ready = 1'b1;
    send(mk_beat(0, 4'b1111, 1'b0));
    send(mk_beat(4, 4'b1111, 1'b0));
    send(mk_beat(8, 4'b1111, 1'b1));
    drain();
    watch_ready = 1'b0;
    check("s2_count", 128'(out_log.size()), 128'(1));
    if (out_log.size() == 1) begin
      check("s2_keep", 128'(out_log[0].keep), 128'(4'b1111));
      check("s2_tag0", 128'(out_log[0].tag[0]), 128'(8));
    end

    // Back-pressure: skid fills after two beats, holds, then drains in order.
    set_cfg(0, 100);
    out_log.delete();
    out_if.ready = 1'b0;
    send(mk_beat(0, 4'b1111, 1'b0));
    send(mk_beat(4, 4'b1111, 1'b0));
    drive(mk_beat(8, 4'b1111, 1'b0));
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 128'(in_if.ready), 128'(0));
    end
    @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    send(mk_beat(8, 4'b1111, 1'b0));
    send(mk_beat(12, 4'b1111, 1'b1));
    drain();
    check("bp_count", 128'(out_log.size()), 128'(4));
    if (out_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check("bp_order", 128'(out_log[k].tag[0]), 128'(4 * k));
    end

    // Config change mid-stream is ignored until the next stream.
    set_cfg(0, 4);
    out_log.delete();
    send(mk_beat(0, 4'b1111, 1'b0));
    set_cfg(4, 8);
    send(mk_beat(4, 4'b1111, 1'b0));
    send(mk_beat(2, 4'b1111, 1'b1));
    send(mk_beat(4, 4'b1111, 1'b1));
    drain();
    check("cfg_count", 128'(out_log.size()), 128'(3));
    if (out_log.size() == 3) begin
      check("cfg_keep0", 128'(out_log[0].keep), 128'(4'b1111));
      check("cfg_keep1", 128'(out_log[1].keep), 128'(4'b0011));
      check("cfg_keep2", 128'(out_log[2].keep), 128'(4'b1111));
    end

    // Empty window: only the last beat survives, with no kept elements.
    set_cfg(5, 5);
    out_log.delete();
    send(mk_beat(4, 4'b1111, 1'b0));
    send(mk_beat(8, 4'b1111, 1'b1));
    drain();
    check("empty_count", 128'(out_log.size()), 128'(1));
    if (out_log.size() == 1) begin
      check("empty_keep", 128'(out_log[0].keep), 128'(4'b0000));
      check("empty_last", 128'(out_log[0].last), 128'(1));
    end

    // Reset mid-stream: buffered beat discarded, FSM back in IDLE, count cleared.
    set_cfg(2, 7);
`ifdef TAGGED_RANGE_FILTER_STATS_EN
    stat_pulses = 0;
`endif
    send(mk_beat(2, 4'b1111, 1'b0));
    drain();
    out_if.ready = 1'b0;
    send(mk_beat(0, 4'b1111, 1'b0));
    do_reset();
    out_if.ready = 1'b1;
`ifdef TAGGED_RANGE_FILTER_STATS_EN
    check("rst_no_pulse", 128'(stat_pulses), 128'(0));
`endif
    set_cfg(8, 12);
    out_log.delete();
    send(mk_beat(8, 4'b1111, 1'b1));
    drain();
    check("post_rst_count", 128'(out_log.size()), 128'(1));
    if (out_log.size() == 1) check("post_rst_keep", 128'(out_log[0].keep), 128'(4'b1111));
`ifdef TAGGED_RANGE_FILTER_STATS_EN
    check("post_rst_pulses", 128'(stat_pulses), 128'(1));
    check("post_rst_kept", 128'(stat_last), 128'(4));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
